// File: rtl/nvram_pkg.sv
// ============================================================================
//  Module      : nvram_pkg
//  Description : Shared types and constants for the NVRAM upload responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nvram_pkg;

    // Upload responder states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READY = 2'd2,
        FETCH = 2'd3
    } state_t;

    // Byte returned for reads that do not touch the RAM
    localparam logic [7:0] FILL_BYTE    = 8'hFF;

    // ioctl_index that selects the NVRAM upload by default
    localparam logic [7:0] DEF_UP_INDEX = 8'd4;

endpackage : nvram_pkg

`default_nettype wire

// File: rtl/nvram_rd_pipe.sv
// ============================================================================
//  Module      : nvram_rd_pipe
//  Description : RAM read-latency tracker. A start pulse loads RD_LAT; the
//                counter then runs down once per clock and o_capture is high
//                for the single cycle in which ram_q must be sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nvram_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_start,
    output logic o_capture
);

    localparam logic [1:0] c_LOAD = 2'(RD_LAT);

    logic [1:0] r_cnt;
    logic       r_run;

    // Load on start, count down while running, stop once the capture cycle is reached
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 2'd0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= c_LOAD;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == 2'd0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    assign o_capture = r_run && (r_cnt == 2'd0);

endmodule : nvram_rd_pipe

`default_nettype wire

// File: rtl/nvram_upload.sv
// ============================================================================
//  Module      : nvram_upload
//  Description : HPS upload responder. Pauses the CPU, takes the work-RAM port
//                and answers each ioctl_rd strobe with one RAM byte on
//                ioctl_din. Addresses >= SIZE return FILL_BYTE.
//                Optional macro NVRAM_UPLOAD_CHECKSUM_EN: an 8-bit running sum
//                of returned bytes; a read at address SIZE returns its two's
//                complement.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nvram_upload
    import nvram_pkg::*;
#(
    parameter int         AW       = 10,
    parameter int         SIZE     = 1024,
    parameter int         RD_LAT   = 1,
    parameter logic [7:0] UP_INDEX = DEF_UP_INDEX
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic          ram_sel,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          busy
);

    // Full 25-bit bound so high address bits are never truncated away
    localparam logic [24:0] c_SIZE = 25'(SIZE);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_active;
    logic          r_active_d;
    logic          r_pend;
    logic [24:0]   r_pend_addr;
    logic [7:0]    r_din;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_rd;
    logic          w_capture;
    logic          w_active_rise;
    logic          w_svc;
    logic [24:0]   w_svc_addr;
    logic          w_in_range;
    logic          w_fetch_go;
    logic          w_enter_ready;
    logic [7:0]    w_oor_byte;

    assign w_active_rise = r_active && !r_active_d;

    // A fresh strobe takes priority over (and supersedes) a parked one
    assign w_svc         = (r_state == READY) && r_active && (ioctl_rd || r_pend);
    assign w_svc_addr    = ioctl_rd ? ioctl_addr : r_pend_addr;
    assign w_in_range    = (w_svc_addr < c_SIZE);
    assign w_fetch_go    = w_svc && w_in_range;
    assign w_enter_ready = (r_state == REQ) && (w_state_nxt == READY);

    nvram_rd_pipe #(
        .RD_LAT    (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_fetch_go),
        .o_capture (w_capture)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; pause_ack is only looked at while requesting
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_active_rise) w_state_nxt = REQ;
            end
            REQ: begin
                if (!r_active)      w_state_nxt = IDLE;
                else if (pause_ack) w_state_nxt = READY;
            end
            READY: begin
                if (!r_active)       w_state_nxt = IDLE;
                else if (w_fetch_go) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_capture) w_state_nxt = r_active ? READY : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Select decode and read strobe/address registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_active_d <= 1'b0;
            r_ram_rd   <= 1'b0;
            r_ram_addr <= '0;
        end else begin
            r_active   <= ioctl_upload && (ioctl_index == UP_INDEX);
            r_active_d <= r_active;
            r_ram_rd   <= w_fetch_go;
            if (w_fetch_go) r_ram_addr <= w_svc_addr[AW-1:0];
        end
    end

    // One-deep pending slot for strobes that arrive while the RAM is not ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else if (w_state_nxt == IDLE) begin
            r_pend      <= 1'b0;
        end else if (ioctl_rd && ((r_state == REQ) || (r_state == FETCH))) begin
            r_pend      <= 1'b1;
            r_pend_addr <= ioctl_addr;
        end else if (w_svc) begin
            r_pend      <= 1'b0;
        end
    end

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    logic [7:0] r_sum;

    // Running sum of returned in-range bytes, cleared when the port is granted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= 8'h00;
        end else if (w_enter_ready) begin
            r_sum <= 8'h00;
        end else if ((r_state == FETCH) && w_capture) begin
            r_sum <= r_sum + ram_q;
        end
    end

    assign w_oor_byte = (w_svc_addr == c_SIZE) ? (8'h00 - r_sum) : FILL_BYTE;
`else
    assign w_oor_byte = FILL_BYTE;
`endif

    // Returned data: RAM byte on fetch completion, fill/checksum byte otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_din <= 8'h00;
        end else if ((r_state == FETCH) && w_capture) begin
            r_din <= ram_q;
        end else if (w_svc && !w_in_range) begin
            r_din <= w_oor_byte;
        end
    end

    assign ioctl_din = r_din;
    assign ram_addr  = r_ram_addr;
    assign ram_rd    = r_ram_rd;
    assign pause_req = (r_state != IDLE);
    assign ram_sel   = (r_state == READY) || (r_state == FETCH);
    assign busy      = (r_state != IDLE);

endmodule : nvram_upload

`default_nettype wire

// File: tb/tb_nvram_upload.sv
// ============================================================================
//  Module      : tb_nvram_upload
//  Description : Self-checking bench for nvram_upload (RD_LAT = 1). Builds
//                with SIZE = 4 when NVRAM_UPLOAD_CHECKSUM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nvram_upload;

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    localparam int c_SIZE = 4;
    localparam bit c_CHK  = 1'b1;
`else
    localparam int c_SIZE = 1024;
    localparam bit c_CHK  = 1'b0;
`endif
    localparam int c_AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_rd = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_din;
    logic          pause_req;
    logic          pause_ack = 1'b0;
    logic          ram_sel;
    logic [c_AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_q = 8'h00;
    logic          busy;

    nvram_upload #(
        .AW(c_AW), .SIZE(c_SIZE), .RD_LAT(1), .UP_INDEX(8'd4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .pause_req(pause_req), .pause_ack(pause_ack),
        .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_q(ram_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model, one clock read latency
    logic [7:0] mem [0:1023];
    int         rd_cnt = 0;
    always @(posedge clk) begin
        if (ram_rd) begin
            ram_q  <= mem[ram_addr];
            rd_cnt  = rd_cnt + 1;
        end
    end

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tb_sum = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference byte for a read at address a; tracks the running checksum
    function automatic logic [7:0] model(input logic [24:0] a);
        logic [7:0] v;
        if (a < 25'(c_SIZE)) begin
            v      = mem[a[9:0]];
            tb_sum = tb_sum + v;
        end else if (c_CHK && a == 25'(c_SIZE)) begin
            v = 8'h00 - tb_sum;
        end else begin
            v = 8'hFF;
        end
        return v;
    endfunction

    // One-cycle strobe; returns at the negedge after the sampling edge
    task automatic issue(input logic [24:0] a, input bit expect_out);
        @(negedge clk);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        if (expect_out) exp_q.push_back(model(a));
        @(negedge clk);
        ioctl_rd   = 1'b0;
    endtask

    typedef struct {
        logic [24:0] addr;
        bit          fetch;
    } vec_t;
    vec_t vecs[8];

    initial begin
        logic [7:0] prev;
        logic [7:0] e;
        int         base;
        bit         done;

        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        vecs[0] = '{25'h0000000, 1'b1}; vecs[1] = '{25'h0000001, 1'b1};
        vecs[2] = '{25'h0000002, 1'b1}; vecs[3] = '{25'h0000003, 1'b1};
        vecs[4] = '{25'h0000004, 1'b0}; vecs[5] = '{25'h0000005, 1'b0};
        vecs[6] = '{25'h1000002, 1'b0}; vecs[7] = '{25'h1FFFFFF, 1'b0};
`else
        mem[12'h012] = 8'hA5;
        vecs[0] = '{25'h0000012, 1'b1}; vecs[1] = '{25'h0000400, 1'b0};
        vecs[2] = '{25'h00003FF, 1'b1}; vecs[3] = '{25'h0000000, 1'b1};
        vecs[4] = '{25'h1000412, 1'b0}; vecs[5] = '{25'h0000401, 1'b0};
        vecs[6] = '{25'h0000155, 1'b1}; vecs[7] = '{25'h1FFFFFF, 1'b0};
`endif

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pause_req", pause_req, 0);
        chk("rst_ram_sel", ram_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_ram_rd", ram_rd, 0);
        reset_n = 1'b1;

        // Wrong index never requests a pause
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd5;
        repeat (6) @(negedge clk);
        chk("wrong_idx_pause_req", pause_req, 0);
        chk("wrong_idx_busy", busy, 0);

        // Matching index: request, then a strobe parked during REQ
        ioctl_index = 8'd4;
        tb_sum      = 8'h00;
        repeat (2) @(negedge clk);
        chk("req_pause_req", pause_req, 1);
        chk("req_ram_sel", ram_sel, 0);
        repeat (2) @(negedge clk);
        issue(25'h003, 1'b1);
        chk("req_no_ram_rd", rd_cnt, 0);
        chk("req_still_waiting", {pause_req, ram_sel}, 2'b10);
        pause_ack = 1'b1;
        @(negedge clk);
        chk("ack_ram_sel", ram_sel, 1);
        done = 1'b0;
        e    = exp_q.pop_front();
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (ioctl_din == e) done = 1'b1;
        end
        chk("pend_served", done, 1);
        chk("pend_din", ioctl_din, e);
        chk("pend_one_rd", rd_cnt, 1);

        // Ack drop while owning the port is ignored
        pause_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("ack_drop_ram_sel", ram_sel, 1);
        chk("ack_drop_pause_req", pause_req, 1);

        // Table of single reads
        for (int i = 0; i < 8; i++) begin
            prev = ioctl_din;
            base = rd_cnt;
            issue(vecs[i].addr, 1'b1);
            if (vecs[i].fetch) begin
                chk($sformatf("v%0d_ram_rd", i), ram_rd, 1);
                chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].addr[9:0]);
                @(negedge clk);
                chk($sformatf("v%0d_ram_rd_pulse", i), ram_rd, 0);
                chk($sformatf("v%0d_din_hold", i), ioctl_din, prev);
                @(negedge clk);
                chk($sformatf("v%0d_din", i), ioctl_din, exp_q.pop_front());
                chk($sformatf("v%0d_rd_cnt", i), rd_cnt - base, 1);
            end else begin
                chk($sformatf("v%0d_din", i), ioctl_din, exp_q.pop_front());
                chk($sformatf("v%0d_no_ram_rd", i), ram_rd, 0);
            end
        end

        // Strobes during FETCH: last address wins
        base = rd_cnt;
        @(negedge clk);
        ioctl_rd = 1'b1; ioctl_addr = 25'h001;
        exp_q.push_back(model(25'h001));
        @(negedge clk);
        ioctl_addr = 25'h002;
        @(negedge clk);
        ioctl_addr = 25'h000;
        exp_q.push_back(model(25'h000));
        @(negedge clk);
        ioctl_rd = 1'b0;
        chk("b2b_first_din", ioctl_din, exp_q.pop_front());
        @(negedge clk);
        chk("b2b_ram_addr", {ram_rd, ram_addr}, {1'b1, 10'h000});
        repeat (2) @(negedge clk);
        chk("b2b_last_din", ioctl_din, exp_q.pop_front());
        chk("b2b_rd_cnt", rd_cnt - base, 2);

        // Upload dropped with the strobe: fetch completes, then release
        base = rd_cnt;
        @(negedge clk);
        ioctl_rd = 1'b1; ioctl_addr = 25'h002; ioctl_upload = 1'b0;
        exp_q.push_back(model(25'h002));
        @(negedge clk);
        ioctl_addr = 25'h001;
        @(negedge clk);
        ioctl_rd = 1'b0;
        @(negedge clk);
        chk("drop_din", ioctl_din, exp_q.pop_front());
        @(negedge clk);
        chk("drop_released", {pause_req, ram_sel, busy}, 3'b000);
        repeat (4) @(negedge clk);
        chk("drop_pend_discarded", rd_cnt - base, 1);

        // Async reset in the middle of a fetch
        ioctl_upload = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (pause_req) done = 1'b1;
        end
        chk("re_req", done, 1);
        pause_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("re_ram_sel", ram_sel, 1);
        issue(25'h001, 1'b0);
        chk("re_fetch_started", ram_rd, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_outs", {pause_req, ram_sel, busy, ram_rd}, 4'b0000);
        chk("async_rst_din", ioctl_din, 8'h00);
        ioctl_upload = 1'b0;
        pause_ack    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_nvram_upload

`default_nettype wire
